// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and default frame parameters,
// common to the transmit drain and the future receive stage.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT = 4;
    localparam int UART_DATA_W       = 8;
    localparam int UART_STOP_BITS    = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clr restarts the bit period so a new frame is aligned to its pop edge.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // Bit-period counter, wrapping at the end of every bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == LAST) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from a show-ahead fifo and serializes them as UART 8N1, LSB first,
// chaining frames back-to-back while the fifo has data and en is high.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_W       = UART_DATA_W,
    parameter int STOP_BITS    = UART_STOP_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    output logic              tx,
    output logic              busy
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t    r_state;
    uart_tx_state_t    w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [IW-1:0]     r_bit_idx;
    logic [IW-1:0]     w_bit_idx_nxt;
    logic              r_stop_idx;
    logic              w_stop_idx_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              w_pop;
    logic              w_can_pop;
    logic              w_bit_end;
    logic              w_baud_clr;

    // rst_n gating keeps the pop strobe low while the block is held in reset
    assign w_can_pop  = rst_n & en & ~fifo_empty;
    assign w_baud_clr = w_pop | (r_state == IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_baud_clr),
        .bit_end(w_bit_end)
    );

    // Frame sequencing: next state, shift data, line level and pop strobe
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_can_pop) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = fifo_data;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = START;
                end else begin
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_tx_nxt      = r_shreg[0];
                    w_bit_idx_nxt = {IW{1'b0}};
                    w_state_nxt   = DATA;
                end else begin
                    w_state_nxt   = START;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_idx == LAST_BIT)) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_idx_nxt = 1'b0;
                    w_state_nxt    = STOP;
                end else if (w_bit_end) begin
                    w_shreg_nxt   = {1'b0, r_shreg[DATA_W-1:1]};
                    w_tx_nxt      = r_shreg[1];
                    w_bit_idx_nxt = r_bit_idx + IW'(1);
                end else begin
                    w_state_nxt   = DATA;
                end
            end
            STOP: begin
                if (w_bit_end && (r_stop_idx == LAST_STOP)) begin
                    // Last stop cycle: chain straight into the next frame when possible
                    if (w_can_pop) begin
                        w_pop       = 1'b1;
                        w_shreg_nxt = fifo_data;
                        w_tx_nxt    = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end else if (w_bit_end) begin
                    w_stop_idx_nxt = 1'b1;
                end else begin
                    w_state_nxt    = STOP;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drives the line idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shreg    <= {DATA_W{1'b0}};
            r_bit_idx  <= {IW{1'b0}};
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign fifo_pop = w_pop;
    assign tx       = r_tx;
    assign busy     = r_busy;

endmodule
